dm_rmw_arbiter: RTL

Sequencer and arbiter in front of the single-port data memory. Two requesters share the memory: port 0 is the CPU memory stage, port 1 is a secondary master (loader/debug). Each request is a word read, a full-word write, or a byte-enabled partial write. Partial writes run as a two-step read-modify-write, so the memory only ever sees whole-word writes.

---
 rtl/dm_rmw_arbiter_pkg.sv | 34 +++
 rtl/dm_rmw_arbiter_if.sv | 31 +++
 rtl/dm_rmw_arbiter_byte_merge.sv | 17 +
 rtl/dm_rmw_arbiter.sv | 116 +++++++++++
 4 files changed

// File: rtl/dm_rmw_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : dm_pkg                                                           |
// | Shared state encoding and byte-enable constants for the data-memory        |
// | read-modify-write arbiter.                                                 |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
package dm_pkg;

    localparam int NPORT = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACC   = 2'd1,
        ST_MERGE = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [3:0] BE_WORD  = 4'b1111;
    localparam logic [3:0] BE_NONE  = 4'b0000;
    localparam logic [3:0] BE_BYTE0 = 4'b0001 << 0;
    localparam logic [3:0] BE_BYTE1 = 4'b0001 << 1;
    localparam logic [3:0] BE_BYTE2 = 4'b0001 << 2;
    localparam logic [3:0] BE_BYTE3 = 4'b0001 << 3;
    localparam logic [3:0] BE_HALF0 = 4'b0011;
    localparam logic [3:0] BE_HALF1 = 4'b1100;

    // Anything other than a full word or an empty mask needs the old word.
    function automatic logic be_is_partial(input logic [3:0] be);
        return (be != BE_WORD) && (be != BE_NONE);
    endfunction

endpackage : dm_pkg
`default_nettype wire

// File: rtl/dm_rmw_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : dm_rmw_arbiter_if                                              |
// | Two-port requester bus of the data-memory arbiter.                         |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
interface dm_rmw_arbiter_if #(
    parameter int AW = 32
);
    logic [1:0]    req;
    logic [1:0]    we;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [31:0]   wd0;
    logic [31:0]   wd1;
    logic [3:0]    be0;
    logic [3:0]    be1;
    logic [1:0]    done;
    logic [31:0]   rdata;

    modport master (
        output req, we, addr0, addr1, wd0, wd1, be0, be1,
        input  done, rdata
    );

    modport slave (
        input  req, we, addr0, addr1, wd0, wd1, be0, be1,
        output done, rdata
    );
endinterface : dm_rmw_arbiter_if
`default_nettype wire

// File: rtl/dm_rmw_arbiter_byte_merge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : byte_merge                                                        |
// | Per-lane merge of a new word into an old word under a byte-enable mask.    |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
module byte_merge (
    input  wire logic [31:0] old_word,
    input  wire logic [31:0] new_word,
    input  wire logic [3:0]  be,
    output logic      [31:0] merged
);
    for (genvar k = 0; k < 4; k++) begin : g_lane
        assign merged[8*k +: 8] = be[k] ? new_word[8*k +: 8] : old_word[8*k +: 8];
    end
endmodule : byte_merge
`default_nettype wire

// File: rtl/dm_rmw_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : dm_rmw_arbiter                                                    |
// | Round-robin arbiter and read-modify-write sequencer for the single-port    |
// | data memory; partial writes become a read followed by a whole-word write.  |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
module dm_rmw_arbiter #(
    parameter int NPORT = 2,
    parameter int AW    = 32
) (
    input  wire logic           CLK,
    input  wire logic           Reset,
    dm_rmw_arbiter_if.slave     bus,
    output logic [AW-1:0]       mem_addr,
    output logic [31:0]         mem_wd,
    output logic                mem_we,
    input  wire logic [31:0]    mem_rd
);
    import dm_pkg::state_t;
    import dm_pkg::ST_IDLE;
    import dm_pkg::ST_ACC;
    import dm_pkg::ST_MERGE;
    import dm_pkg::ST_RESP;
    import dm_pkg::BE_WORD;
    import dm_pkg::be_is_partial;

    state_t        r_state;
    state_t        w_next;
    logic          r_port;
    logic          r_last;
    logic          r_we;
    logic [AW-1:2] r_addr;
    logic [31:0]   r_wd;
    logic [3:0]    r_be;
    logic [31:0]   r_rdata;
    logic [31:0]   r_merge;

    logic             w_grant;
    logic             w_partial;
    logic [31:0]      w_merged;
    logic [NPORT-1:0] w_done;
    logic             w_unused_addr_lsb;

    // Only the word address is stored; the byte offset never reaches memory.
    assign w_unused_addr_lsb = ^{bus.addr0[1:0], bus.addr1[1:0]};

    // On a tie the port that was not served last wins.
    assign w_grant   = (bus.req == 2'b11) ? ~r_last : bus.req[1];
    assign w_partial = r_we && be_is_partial(r_be);

    byte_merge u_byte_merge (
        .old_word (r_merge),
        .new_word (r_wd),
        .be       (r_be),
        .merged   (w_merged)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (|bus.req) w_next = ST_ACC;
            ST_ACC:   w_next = w_partial ? ST_MERGE : ST_RESP;
            ST_MERGE: w_next = ST_RESP;
            ST_RESP:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_IDLE;
            r_port  <= 1'b0;
            r_last  <= 1'b1;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wd    <= '0;
            r_be    <= '0;
            r_rdata <= '0;
            r_merge <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    if (|bus.req) begin
                        r_port <= w_grant;
                        r_we   <= bus.we[w_grant];
                        r_addr <= w_grant ? bus.addr1[AW-1:2] : bus.addr0[AW-1:2];
                        r_wd   <= w_grant ? bus.wd1 : bus.wd0;
                        r_be   <= w_grant ? bus.be1 : bus.be0;
                    end
                end
                ST_ACC: begin
                    if (!r_we)
                        r_rdata <= mem_rd;
                    else if (w_partial)
                        r_merge <= mem_rd;
                end
                ST_RESP: r_last <= r_port;
                default: ;
            endcase
        end
    end

    assign mem_addr = {r_addr, 2'b00};
    assign mem_we   = ((r_state == ST_ACC) && r_we && (r_be == BE_WORD)) ||
                      (r_state == ST_MERGE);
    assign mem_wd   = (r_state == ST_MERGE)         ? w_merged :
                      ((r_state == ST_ACC) && r_we) ? r_wd     : 32'd0;

    assign w_done    = (r_state == ST_RESP) ? ({{(NPORT-1){1'b0}}, 1'b1} << r_port) : '0;
    assign bus.done  = w_done;
    assign bus.rdata = r_rdata;

endmodule : dm_rmw_arbiter
`default_nettype wire
